alu_resp_checker: RTL and testbench

ALU_RESP_CHECKER -- requirements
Module: alu_resp_checker

---
 rtl/alu_resp_checker.sv | 103 ++++++++++
 tb/tb_alu_resp_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: counts ALU results that match/mismatch a bitwise reference over a run of vectors
//   clk, rst (sync active-high) | start, num_vec: begin a run of num_vec vectors
//   in_valid/in_ready, a, b, op, y: one vector per transfer | busy, done: run status
//   pass_cnt, fail_cnt, first_fail_idx, first_fail_vld: results | signature: MISR of y
//   Optional MISR enabled by macro ALU_RESP_CHECKER_SIG_EN (signature is 0 otherwise)
module alu_resp_checker #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] num_vec,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [1:0]    op,
    input  logic [W-1:0]  y,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic [CW-1:0] first_fail_idx,
    output logic          first_fail_vld,
    output logic [W-1:0]  signature
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] num_q, num_d, idx_q, idx_d, pass_q, pass_d, fail_q, fail_d, ffi_q, ffi_d;
    logic          ffv_q, ffv_d;
    logic [W-1:0]  exp_v;
    logic          match, accept, xfer, last;
    assign exp_v  = op == 2'b00 ? a & b : op == 2'b01 ? a | b : op == 2'b10 ? a ^ b : ~(a | b);
    assign match  = y == exp_v;
    assign accept = start && state_q != RUN;
    assign xfer   = in_valid && state_q == RUN;
    assign last   = idx_q == num_q - CW'(1);
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        if (accept) begin
            state_d = num_vec == '0 ? DONE : RUN;
            num_d   = num_vec;
            idx_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            ffi_d   = '0;
            ffv_d   = 1'b0;
        end else if (xfer) begin
            pass_d  = pass_q + CW'(match);
            fail_d  = fail_q + CW'(!match);
            ffi_d   = !match && !ffv_q ? idx_q : ffi_q;
            ffv_d   = ffv_q || !match;
            idx_d   = last ? idx_q : idx_q + CW'(1);
            state_d = last ? DONE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffi_q   <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end
    assign busy           = state_q == RUN;
    assign in_ready       = state_q == RUN;
    assign done           = state_q == DONE;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail_idx = ffi_q;
    assign first_fail_vld = ffv_q;
`ifdef ALU_RESP_CHECKER_SIG_EN
    logic [W-1:0] sig_q, sig_d;
    always_comb begin
        sig_d = accept ? '1 : xfer ? {sig_q[W-2:0], sig_q[W-1] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ y : sig_q;
    end
    always_ff @(posedge clk) begin
        if (rst) sig_q <= '0;
        else sig_q <= sig_d;
    end
    assign signature = sig_q;
`else
    assign signature = '0;
`endif
endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker: randomized and directed checks of alu_resp_checker against a behavioural model
module tb_alu_resp_checker;
    localparam int W  = 32;
    localparam int CW = 16;
    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_ready, busy, done, first_fail_vld;
    logic [CW-1:0] num_vec, pass_cnt, fail_cnt, first_fail_idx;
    logic [W-1:0]  a, b, y, signature;
    logic [1:0]    op;
    int            n_cmp = 0, n_bad = 0;
    bit            chk_on = 0;
    bit            m_busy, m_done, m_ffv;
    int            m_left, m_n, m_pass, m_fail, m_ffi;
    logic [W-1:0]  m_sig;

    alu_resp_checker #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .op(op), .y(y), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld), .signature(signature)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu(logic [W-1:0] x, logic [W-1:0] z, logic [1:0] o);
        case (o)
            2'b00:   return x & z;
            2'b01:   return x | z;
            2'b10:   return x ^ z;
            default: return ~(x | z);
        endcase
    endfunction

    function automatic logic [W-1:0] misr(logic [W-1:0] s, logic [W-1:0] d);
        return {s[W-2:0], s[W-1] ^ s[21] ^ s[1] ^ s[0]} ^ d;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: a run is a countdown of remaining transfers
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_done <= 0; m_left <= 0; m_n <= 0;
            m_pass <= 0; m_fail <= 0; m_ffi <= 0; m_ffv <= 0; m_sig <= '0;
        end else if (start && !m_busy) begin
            m_busy <= num_vec != 0;
            m_done <= num_vec == 0;
            m_left <= int'(num_vec);
            m_n <= 0; m_pass <= 0; m_fail <= 0; m_ffi <= 0; m_ffv <= 0;
            m_sig <= '1;
        end else if (m_busy && in_valid) begin
            m_pass <= m_pass + int'(y == alu(a, b, op));
            m_fail <= m_fail + int'(y != alu(a, b, op));
            if (y != alu(a, b, op) && !m_ffv) begin
                m_ffi <= m_n;
                m_ffv <= 1;
            end
            m_n <= m_n + 1;
            m_left <= m_left - 1;
            m_sig <= misr(m_sig, y);
            if (m_left == 1) begin
                m_busy <= 0;
                m_done <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("in_ready", in_ready, m_busy);
            chk("pass_cnt", pass_cnt, m_pass);
            chk("fail_cnt", fail_cnt, m_fail);
            chk("first_fail_vld", first_fail_vld, m_ffv);
            if (m_ffv) chk("first_fail_idx", first_fail_idx, m_ffi);
`ifdef ALU_RESP_CHECKER_SIG_EN
            chk("signature", signature, m_sig);
`else
            chk("signature", signature, 0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(int n);
        start = 1; num_vec = CW'(n);
        tick();
        start = 0;
    endtask

    task automatic vec(logic [W-1:0] aa, logic [W-1:0] bb, logic [1:0] oo, logic [W-1:0] yy);
        a = aa; b = bb; op = oo; y = yy; in_valid = 1;
        tick();
        in_valid = 0;
        a = $urandom; b = $urandom; y = $urandom;
    endtask

    task automatic rnd_vec(bit bad);
        logic [W-1:0] aa, bb;
        logic [1:0]   oo;
        aa = $urandom; bb = $urandom; oo = 2'($urandom_range(0, 3));
        vec(aa, bb, oo, alu(aa, bb, oo) ^ (bad ? W'(1) << $urandom_range(0, W - 1) : '0));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50 && !done; i++) tick();
        chk("done_within_bound", done, 1);
    endtask

    initial begin
        rst = 1; start = 0; in_valid = 0; num_vec = '0; a = '0; b = '0; y = '0; op = 2'b00;
        tick();
        chk_on = 1;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ffv", first_fail_vld, 0);
        chk("rst_sig", signature, 0);
        rst = 0;
        tick();
        // single all-ones AND vector
        start_run(1);
        chk("r1_busy", busy, 1);
        vec('1, '1, 2'b00, '1);
        chk("r1_done", done, 1);
        chk("r1_pass", pass_cnt, 1);
        chk("r1_fail", fail_cnt, 0);
        chk("r1_ffv", first_fail_vld, 0);
        // three AND vectors, all correct
        start_run(3);
        vec(32'hFFFFFFFF, 32'h771FFE01, 2'b00, 32'h771FFE01);
        vec(32'h03AF5554, 32'h00000000, 2'b00, 32'h00000000);
        vec(32'hC15DF831, 32'hFE7BF557, 2'b00, 32'hC059F011);
        chk("r3_done", done, 1);
        chk("r3_pass", pass_cnt, 3);
`ifndef ALU_RESP_CHECKER_SIG_EN
        chk("r3_sig_zero", signature, 0);
`endif
        // in_valid while DONE is ignored
        vec('1, '0, 2'b00, '1);
        chk("done_hold_pass", pass_cnt, 3);
        chk("done_hold_fail", fail_cnt, 0);
        // index 2 off by bit0, index 3 off by MSB
        start_run(4);
        vec(32'h0F0F0F0F, 32'h00FF00FF, 2'b01, 32'h0FFF0FFF);
        vec(32'h0F0F0F0F, 32'h00FF00FF, 2'b10, 32'h0FF00FF0);
        vec(32'h12345678, 32'h00000000, 2'b11, 32'hEDCBA986);
        vec(32'hAAAAAAAA, 32'hAAAAAAAA, 2'b00, 32'h2AAAAAAA);
        chk("r4_pass", pass_cnt, 2);
        chk("r4_fail", fail_cnt, 2);
        chk("r4_ffi", first_fail_idx, 2);
        chk("r4_ffv", first_fail_vld, 1);
        // zero-length run
        start_run(0);
        chk("r0_done", done, 1);
        chk("r0_busy", busy, 0);
        chk("r0_pass", pass_cnt, 0);
        chk("r0_fail", fail_cnt, 0);
        // gaps and a stray start mid-run
        start_run(6);
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < 2; g++) tick();
            if (i == 3) begin
                start = 1; num_vec = 2; tick(); start = 0;
            end
            rnd_vec(i == 1);
            if (i == 4) chk("gap_still_busy", busy, 1);
        end
        chk("gap_done", done, 1);
        chk("gap_total", 32'(pass_cnt) + 32'(fail_cnt), 6);
        chk("gap_ffi", first_fail_idx, 1);
        // reset mid-run after 2 of 5
        start_run(5);
        rnd_vec(1);
        rnd_vec(0);
        rst = 1; start = 1; in_valid = 1;
        tick();
        rst = 0; start = 0; in_valid = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass_cnt, 0);
        chk("abort_fail", fail_cnt, 0);
        chk("abort_ffv", first_fail_vld, 0);
        chk("abort_sig", signature, 0);
        // randomized runs
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 12);
            start_run(n);
            for (int i = 0; i < n; i++) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    start = ($urandom_range(0, 7) == 0);
                    num_vec = CW'($urandom);
                    tick();
                    start = 0;
                end
                rnd_vec($urandom_range(0, 3) == 0);
            end
            wait_done();
            if ($urandom_range(0, 1) == 1) rnd_vec(0);
        end
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
